// File: rtl/spi_job_scheduler.sv
// Round-robin scheduler sharing one SPI master and enc/dec slave between two
// requesters: grant, load, shift TX, wait for the slave, collect RX, respond.
`timescale 1ns/1ps
module spi_job_scheduler #(
    parameter int NK      = 8,
    parameter int NB      = 4,
    parameter int NR      = 14,
    parameter int TIMEOUT = 1024
) (
    input  logic             in_clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_mode,
    input  logic [32*NB-1:0] req0_msg,
    input  logic [32*NK-1:0] req0_key,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_mode,
    input  logic [32*NB-1:0] req1_msg,
    input  logic [32*NK-1:0] req1_key,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic             rsp_err,
    output logic [32*NB-1:0] rsp_data,
    output logic             spi_load,
    output logic             spi_mode,
    output logic [32*NB-1:0] spi_msg,
    output logic [32*NK-1:0] spi_key,
    output logic             spi_cs,
    input  logic             data_done,
    input  logic [32*NB-1:0] spi_rx_data
);

    localparam int MSG_W  = 32 * NB;
    localparam int KEY_W  = 32 * NK;
    localparam int TX_LEN = MSG_W + KEY_W;
    localparam int CW     = $clog2(TX_LEN);
    localparam int TW     = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] TX_LAST  = CW'(TX_LEN - 1);
    localparam logic [CW-1:0] RX_LAST  = CW'(MSG_W - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    // NR only travels with the job; it is checked here and nowhere else.
    if (NR < 1) begin : g_bad_nr
        $error("spi_job_scheduler: NR must be positive");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TX,
        S_WAIT,
        S_RX,
        S_RESP
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   bit_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            rr_last;
    logic            cur_id;
    logic            grant;
    logic            pick;

    always_comb begin
        grant = req0_valid | req1_valid;
        pick  = 1'b0;
        if (req0_valid && req1_valid) begin
            pick = ~rr_last;
        end else if (req1_valid) begin
            pick = 1'b1;
        end
    end

    // Ready is gated by rst so every output reads 0 while reset is held.
    assign req0_ready = rst && (state_q == S_IDLE) && grant && !pick;
    assign req1_ready = rst && (state_q == S_IDLE) && grant && pick;

    assign spi_load  = (state_q == S_LOAD);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = cur_id;
    assign spi_cs    = (state_q == S_LOAD) || (state_q == S_TX) ||
                       (state_q == S_WAIT) || (state_q == S_RX);

    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (grant) state_d = S_LOAD;
            S_LOAD: state_d = S_TX;
            S_TX:   if (bit_cnt == TX_LAST) state_d = S_WAIT;
            S_WAIT: begin
                if (data_done) begin
                    state_d = S_RX;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_d = S_RESP;
                end
            end
            S_RX:   if (data_done && bit_cnt == RX_LAST) state_d = S_RESP;
            S_RESP: if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            bit_cnt  <= '0;
            tmo_cnt  <= '0;
            rr_last  <= 1'b1;
            cur_id   <= 1'b0;
            spi_mode <= 1'b0;
            spi_msg  <= '0;
            spi_key  <= '0;
            rsp_err  <= 1'b0;
            rsp_data <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (grant) begin
                        cur_id   <= pick;
                        rr_last  <= pick;
                        spi_mode <= pick ? req1_mode : req0_mode;
                        spi_msg  <= pick ? req1_msg  : req0_msg;
                        spi_key  <= pick ? req1_key  : req0_key;
                        rsp_err  <= 1'b0;
                    end
                end
                S_LOAD: bit_cnt <= '0;
                S_TX: begin
                    if (bit_cnt == TX_LAST) begin
                        bit_cnt <= '0;
                        tmo_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (!data_done && tmo_cnt == TMO_LAST) begin
                        rsp_err  <= 1'b1;
                        rsp_data <= '0;
                    end
                end
                S_RX: begin
                    // Count only while the slave holds data_done.
                    if (data_done) begin
                        if (bit_cnt == RX_LAST) begin
                            rsp_data <= spi_rx_data;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
                S_RESP: if (rsp_ready) rsp_err <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_job_scheduler.sv
// Randomized bench for spi_job_scheduler with a cycle-count reference model.
`timescale 1ns/1ps
module tb_spi_job_scheduler;

    localparam int MSG_W   = 128;
    localparam int KEY_W   = 256;
    localparam int TXL     = MSG_W + KEY_W;
    localparam int TIMEOUT = 16;

    typedef logic [MSG_W-1:0] msg_t;
    typedef logic [KEY_W-1:0] key_t;

    logic in_clk = 1'b0;
    logic rst = 1'b0;
    logic req0_valid = 1'b0, req0_mode = 1'b0;
    msg_t req0_msg = '0;
    key_t req0_key = '0;
    logic req1_valid = 1'b0, req1_mode = 1'b0;
    msg_t req1_msg = '0;
    key_t req1_key = '0;
    logic rsp_ready = 1'b0, data_done = 1'b0;
    msg_t spi_rx_data = '0;
    logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err;
    logic spi_load, spi_mode, spi_cs;
    msg_t rsp_data, spi_msg;
    key_t spi_key;

    spi_job_scheduler #(.NK(8), .NB(4), .NR(14), .TIMEOUT(TIMEOUT)) dut (
        .in_clk(in_clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
        .req0_msg(req0_msg), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
        .req1_msg(req1_msg), .req1_key(req1_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_err(rsp_err), .rsp_data(rsp_data),
        .spi_load(spi_load), .spi_mode(spi_mode), .spi_msg(spi_msg),
        .spi_key(spi_key), .spi_cs(spi_cs),
        .data_done(data_done), .spi_rx_data(spi_rx_data)
    );

    always #5 in_clk = ~in_clk;

    int n_checks = 0;
    int n_fail = 0;
    logic mdl_last;

    logic [1:0] o_rdy, o_post_rdy;
    logic o_load, o_cs0, o_mode, o_cs_resp, o_after_valid, o_after_err;
    logic o_id, o_err, o_exp_err;
    msg_t o_msg, o_data, o_exp_data;
    key_t o_key;
    int o_resp_k, o_exp_k, o_bad, o_hold_bad;

    function automatic msg_t rnd_msg();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic key_t rnd_key();
        return {rnd_msg(), rnd_msg()};
    endfunction

    task automatic scramble();
        req0_mode = 1'($urandom());
        req0_msg  = rnd_msg();
        req0_key  = rnd_key();
        req1_mode = 1'($urandom());
        req1_msg  = rnd_msg();
        req1_key  = rnd_key();
    endtask

    // Drives one job from an IDLE cycle and records what the ports show.
    // The expected timing is derived from the phase lengths: a 1-cycle LOAD,
    // TXL cycles of TX, WAIT until data_done or TIMEOUT cycles, then MSG_W
    // counted RX cycles plus any cycles where data_done was low.
    task automatic run_job(
        input logic v0, input logic v1, input logic h0, input logic h1,
        input logic m0, input logic m1, input msg_t g0, input msg_t g1,
        input key_t k0, input key_t k1,
        input int dly, input int gat, input int glen, input int bp,
        input logic rnd_rx, input msg_t rx_fix
    );
        int k, w, rxs;
        msg_t rxh [0:1023];
        req0_valid = v0; req0_mode = m0; req0_msg = g0; req0_key = k0;
        req1_valid = v1; req1_mode = m1; req1_msg = g1; req1_key = k1;
        data_done = 1'b0;
        rsp_ready = 1'b0;
        #1;
        o_rdy = {req1_ready, req0_ready};
        @(posedge in_clk); #1;
        req0_valid = h0;
        req1_valid = h1;
        scramble();
        o_load = spi_load; o_cs0 = spi_cs; o_mode = spi_mode;
        o_msg = spi_msg; o_key = spi_key;
        w = TXL + 1;
        o_exp_err = (dly < 0) || (dly >= TIMEOUT);
        rxs = w + dly + 1;
        o_exp_k = o_exp_err ? w + TIMEOUT : rxs + MSG_W + glen;
        o_bad = 0;
        o_resp_k = -1;
        o_cs_resp = 1'bx;
        k = 0;
        while (o_resp_k < 0 && k < 1000) begin
            data_done = !o_exp_err && (k >= w + dly) &&
                        !(k >= rxs + gat && k < rxs + gat + glen);
            rxh[k] = rnd_rx ? rnd_msg() : rx_fix;
            spi_rx_data = rxh[k];
            @(posedge in_clk); #1;
            k++;
            if (rsp_valid) begin
                o_resp_k = k;
                o_cs_resp = spi_cs;
            end else if (spi_cs !== 1'b1 || spi_load !== 1'b0 ||
                         spi_mode !== o_mode || spi_msg !== o_msg ||
                         spi_key !== o_key) begin
                o_bad++;
            end
            if (req0_ready || req1_ready) o_bad++;
        end
        o_exp_data = o_exp_err ? '0 : rxh[o_exp_k-1];
        o_id = rsp_id; o_err = rsp_err; o_data = rsp_data;
        data_done = 1'b0;
        o_hold_bad = 0;
        for (int i = 0; i < bp; i++) begin
            scramble();
            @(posedge in_clk); #1;
            if (rsp_valid !== 1'b1 || rsp_id !== o_id || rsp_err !== o_err ||
                rsp_data !== o_data || spi_cs !== 1'b0 ||
                req0_ready || req1_ready) o_hold_bad++;
        end
        rsp_ready = 1'b1;
        @(posedge in_clk); #1;
        rsp_ready = 1'b0;
        o_after_valid = rsp_valid;
        o_after_err = rsp_err;
        o_post_rdy = {req1_ready, req0_ready};
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (3) @(posedge in_clk);
        #1;
        n_checks++; if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, spi_load, spi_mode, spi_cs} !== 8'b0 || rsp_data !== '0 || spi_msg !== '0 || spi_key !== '0) begin n_fail++; $display("FAIL reset_outputs: got rdy=%b%b v=%b cs=%b load=%b exp all zero", req1_ready, req0_ready, rsp_valid, spi_cs, spi_load); end
        rst = 1'b1;
        mdl_last = 1'b1;
        #1;
        n_checks++; if ({req1_ready, req0_ready} !== 2'b01) begin n_fail++; $display("FAIL reset_first_grant: got %b exp 01", {req1_ready, req0_ready}); end
    endtask

    task automatic test_contention();
        msg_t a, b;
        key_t ka, kb;
        logic ex;
        for (int j = 0; j < 4; j++) begin
            a = rnd_msg(); b = rnd_msg(); ka = rnd_key(); kb = rnd_key();
            ex = ~mdl_last;
            mdl_last = ex;
            run_job(1'b1, 1'b1, j < 3, j < 3, 1'b0, 1'b1, a, b, ka, kb,
                    int'($urandom_range(15, 0)), 500, 0, 0, 1'b1, '0);
            n_checks++; if (o_rdy !== (ex ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL contention_grant[%0d]: got %b exp port %0d", j, o_rdy, ex); end
            n_checks++; if (o_msg !== (ex ? b : a) || o_key !== (ex ? kb : ka) || o_mode !== ex) begin n_fail++; $display("FAIL contention_latch[%0d]: got msg %h exp %h", j, o_msg, ex ? b : a); end
            n_checks++; if (o_resp_k !== o_exp_k || o_id !== ex || o_err !== 1'b0) begin n_fail++; $display("FAIL contention_rsp[%0d]: got k=%0d id=%b err=%b exp k=%0d id=%b err=0", j, o_resp_k, o_id, o_err, o_exp_k, ex); end
            n_checks++; if (o_data !== o_exp_data || o_bad !== 0) begin n_fail++; $display("FAIL contention_data[%0d]: got %h bad=%0d exp %h bad=0", j, o_data, o_bad, o_exp_data); end
        end
    endtask

    task automatic test_single();
        msg_t m, rx;
        key_t kk;
        m  = 128'h00112233445566778899aabbccddeeff;
        kk = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        rx = 128'h8ea2b7ca516745bfeafc49904b496089;
        mdl_last = 1'b0;
        run_job(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m, rnd_msg(), kk, rnd_key(),
                0, 500, 0, 0, 1'b0, rx);
        n_checks++; if (o_rdy !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b exp 01", o_rdy); end
        n_checks++; if (o_load !== 1'b1 || o_cs0 !== 1'b1) begin n_fail++; $display("FAIL single_load: got load=%b cs=%b exp 1 1", o_load, o_cs0); end
        n_checks++; if (o_mode !== 1'b0 || o_msg !== m || o_key !== kk) begin n_fail++; $display("FAIL single_latch: got mode=%b msg=%h exp 0 %h", o_mode, o_msg, m); end
        n_checks++; if (o_resp_k !== TXL + 1 + 1 + MSG_W) begin n_fail++; $display("FAIL single_latency: got %0d exp %0d", o_resp_k, TXL + 1 + 1 + MSG_W); end
        n_checks++; if (o_id !== 1'b0 || o_err !== 1'b0 || o_data !== rx) begin n_fail++; $display("FAIL single_rsp: got id=%b err=%b data=%h exp 0 0 %h", o_id, o_err, o_data, rx); end
        n_checks++; if (o_bad !== 0 || o_cs_resp !== 1'b0) begin n_fail++; $display("FAIL single_cs: got bad=%0d cs_resp=%b exp 0 0", o_bad, o_cs_resp); end
        n_checks++; if (o_after_valid !== 1'b0 || o_post_rdy !== 2'b00) begin n_fail++; $display("FAIL single_done: got valid=%b rdy=%b exp 0 00", o_after_valid, o_post_rdy); end
    endtask

    task automatic test_timeout();
        mdl_last = 1'b1;
        run_job(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, rnd_msg(), rnd_msg(),
                rnd_key(), rnd_key(), -1, 500, 0, 2, 1'b1, '0);
        n_checks++; if (o_rdy !== 2'b10) begin n_fail++; $display("FAIL timeout_grant: got %b exp 10", o_rdy); end
        n_checks++; if (o_resp_k !== TXL + 1 + TIMEOUT) begin n_fail++; $display("FAIL timeout_latency: got %0d exp %0d", o_resp_k, TXL + 1 + TIMEOUT); end
        n_checks++; if (o_err !== 1'b1 || o_data !== '0 || o_id !== 1'b1) begin n_fail++; $display("FAIL timeout_rsp: got err=%b data=%h id=%b exp 1 0 1", o_err, o_data, o_id); end
        n_checks++; if (o_cs_resp !== 1'b0 || o_hold_bad !== 0) begin n_fail++; $display("FAIL timeout_cs: got cs=%b hold_bad=%0d exp 0 0", o_cs_resp, o_hold_bad); end
        n_checks++; if (o_after_err !== 1'b0 || o_after_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got err=%b valid=%b exp 0 0", o_after_err, o_after_valid); end
        mdl_last = 1'b0;
        run_job(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rnd_msg(), rnd_msg(),
                rnd_key(), rnd_key(), TIMEOUT - 1, 500, 0, 0, 1'b1, '0);
        n_checks++; if (o_err !== 1'b0 || o_resp_k !== o_exp_k || o_data !== o_exp_data) begin n_fail++; $display("FAIL timeout_edge_done_wins: got err=%b k=%0d exp err=0 k=%0d", o_err, o_resp_k, o_exp_k); end
    endtask

    task automatic test_backpressure();
        mdl_last = 1'b0;
        run_job(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, rnd_msg(), rnd_msg(),
                rnd_key(), rnd_key(), int'($urandom_range(15, 0)), 500, 0, 50,
                1'b1, '0);
        n_checks++; if (o_rdy !== 2'b01 || o_bad !== 0) begin n_fail++; $display("FAIL bp_grant: got rdy=%b bad=%0d exp 01 0", o_rdy, o_bad); end
        n_checks++; if (o_hold_bad !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable cycles exp 0", o_hold_bad); end
        n_checks++; if (o_resp_k !== o_exp_k || o_data !== o_exp_data || o_id !== 1'b0) begin n_fail++; $display("FAIL bp_rsp: got k=%0d data=%h exp k=%0d data=%h", o_resp_k, o_data, o_exp_k, o_exp_data); end
        n_checks++; if (o_post_rdy !== 2'b10) begin n_fail++; $display("FAIL bp_regrant: got %b exp 10", o_post_rdy); end
        mdl_last = 1'b1;
        run_job(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, rnd_msg(), rnd_msg(),
                rnd_key(), rnd_key(), 3, 500, 0, 0, 1'b1, '0);
        n_checks++; if (o_rdy !== 2'b10 || o_id !== 1'b1 || o_resp_k !== o_exp_k || o_data !== o_exp_data) begin n_fail++; $display("FAIL bp_next_job: got rdy=%b id=%b k=%0d exp 10 1 %0d", o_rdy, o_id, o_resp_k, o_exp_k); end
    endtask

    task automatic test_reset_mid_tx();
        req0_valid = 1'b1; req1_valid = 1'b0;
        scramble();
        #1;
        n_checks++; if ({req1_ready, req0_ready} !== 2'b01) begin n_fail++; $display("FAIL rst_mid_grant: got %b exp 01", {req1_ready, req0_ready}); end
        @(posedge in_clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        n_checks++; if (spi_load !== 1'b1) begin n_fail++; $display("FAIL rst_mid_load: got %b exp 1", spi_load); end
        repeat (101) @(posedge in_clk);
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, spi_load, spi_mode, spi_cs} !== 8'b0 || rsp_data !== '0 || spi_msg !== '0 || spi_key !== '0) begin n_fail++; $display("FAIL rst_mid_async: got cs=%b rdy=%b%b v=%b exp all zero", spi_cs, req1_ready, req0_ready, rsp_valid); end
        repeat (2) @(posedge in_clk);
        #1;
        n_checks++; if (rsp_valid !== 1'b0 || spi_cs !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_hold: got v=%b cs=%b rdy=%b exp 0 0 0", rsp_valid, spi_cs, req1_ready); end
        rst = 1'b1;
        mdl_last = 1'b1;
        run_job(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, rnd_msg(), rnd_msg(),
                rnd_key(), rnd_key(), 0, 500, 0, 0, 1'b1, '0);
        n_checks++; if (o_rdy !== 2'b10 || o_load !== 1'b1) begin n_fail++; $display("FAIL rst_mid_regrant: got rdy=%b load=%b exp 10 1", o_rdy, o_load); end
        n_checks++; if (o_resp_k !== TXL + 1 + 1 + MSG_W || o_id !== 1'b1 || o_data !== o_exp_data || o_bad !== 0) begin n_fail++; $display("FAIL rst_mid_full_job: got k=%0d id=%b bad=%0d exp %0d 1 0", o_resp_k, o_id, o_bad, TXL + 1 + 1 + MSG_W); end
    endtask

    task automatic test_glitch();
        int d;
        d = int'($urandom_range(15, 0));
        mdl_last = 1'b0;
        run_job(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rnd_msg(), rnd_msg(),
                rnd_key(), rnd_key(), d, 60, 5, 0, 1'b1, '0);
        n_checks++; if (o_resp_k - (TXL + 1 + d + 1) !== 133) begin n_fail++; $display("FAIL glitch_rx_len: got %0d exp 133", o_resp_k - (TXL + 1 + d + 1)); end
        n_checks++; if (o_data !== o_exp_data || o_err !== 1'b0 || o_bad !== 0) begin n_fail++; $display("FAIL glitch_capture: got %h err=%b exp %h err=0", o_data, o_err, o_exp_data); end
    endtask

    task automatic test_back_to_back();
        logic v0, v1, ex;
        msg_t a, b;
        key_t ka, kb;
        int d;
        for (int j = 0; j < 6; j++) begin
            v0 = 1'($urandom());
            v1 = 1'($urandom());
            if (!v0 && !v1) v0 = 1'b1;
            a = rnd_msg(); b = rnd_msg(); ka = rnd_key(); kb = rnd_key();
            d = int'($urandom_range(16, 0)) - 1;
            ex = (v0 && v1) ? ~mdl_last : v1;
            mdl_last = ex;
            run_job(v0, v1, 1'($urandom()), 1'($urandom()), 1'($urandom()),
                    1'($urandom()), a, b, ka, kb, d,
                    int'($urandom_range(127, 0)), int'($urandom_range(6, 0)),
                    int'($urandom_range(3, 0)), 1'b1, '0);
            n_checks++; if (o_rdy !== (ex ? 2'b10 : 2'b01) || o_msg !== (ex ? b : a) || o_key !== (ex ? kb : ka)) begin n_fail++; $display("FAIL b2b_grant[%0d]: got rdy=%b exp port %0d", j, o_rdy, ex); end
            n_checks++; if (o_resp_k !== o_exp_k || o_id !== ex || o_err !== o_exp_err) begin n_fail++; $display("FAIL b2b_rsp[%0d]: got k=%0d id=%b err=%b exp %0d %b %b", j, o_resp_k, o_id, o_err, o_exp_k, ex, o_exp_err); end
            n_checks++; if (o_data !== o_exp_data || o_bad !== 0 || o_hold_bad !== 0 || o_after_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h bad=%0d/%0d exp %h", j, o_data, o_bad, o_hold_bad, o_exp_data); end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_timeout();
        test_backpressure();
        test_reset_mid_tx();
        test_glitch();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_job_scheduler.md
Name: spi_job_scheduler

Overview:
- Arbitrates two requester ports for one shared SPI master and enc/dec slave.
- Sequences each job: load message and key, shift TX, wait for slave completion, collect RX, return result.
- Sits between host-side job sources and the SPI master's parallel load and capture interface.
- Grants are round-robin. One job is in flight at a time.

Parameters:
- NK, 8, key words (key width KEY_W = 32*NK)
- NB, 4, block words (message width MSG_W = 32*NB)
- NR, 14, rounds; passed through only, no logic depends on it
- TIMEOUT, 1024, max in_clk cycles spent in WAIT before the job aborts

Ports:
- in_clk  in  1  system clock; all logic on posedge
- rst  in  1  asynchronous active-low reset
- req0_valid  in  1  job request, port 0
- req0_ready  out  1  port 0 job accepted this cycle
- req0_mode  in  1  0 = encrypt, 1 = decrypt
- req0_msg  in  MSG_W  plaintext or ciphertext
- req0_key  in  KEY_W  key
- req1_valid, req1_ready, req1_mode, req1_msg, req1_key: same as port 0, for port 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester index of the result
- rsp_err  out  1  job timed out
- rsp_data  out  MSG_W  result block
- spi_load  out  1  one-cycle pulse; SPI master latches spi_msg/spi_key
- spi_mode  out  1  mode of the current job
- spi_msg  out  MSG_W  message to the master
- spi_key  out  KEY_W  key to the master
- spi_cs  out  1  chip select to the slave, high while a job is active
- data_done  in  1  slave result-ready flag
- spi_rx_data  in  MSG_W  master's receive shift register

Behaviour:
- Reset (rst=0, async): state=IDLE, all outputs 0, counters 0, rr_last=1 so port 0 wins first.
- States: IDLE, LOAD, TX, WAIT, RX, RESP.
- IDLE:
  - If any reqX_valid is set, grant one port. When both are valid, grant the port != rr_last.
  - Assert the granted reqX_ready for exactly 1 cycle.
  - Latch mode, msg and key into spi_mode/spi_msg/spi_key. Latch the index into cur_id and rr_last.
  - Go to LOAD.
- LOAD: spi_load=1 and spi_cs=1 for 1 cycle. Clear bit_cnt. Go to TX.
- TX: increment bit_cnt each cycle. When bit_cnt == MSG_W+KEY_W-1, clear bit_cnt and the timeout counter, then go to WAIT. At defaults TX lasts 384 cycles.
- WAIT:
  - Timeout counter increments each cycle.
  - If data_done=1, go to RX; data_done wins over timeout when both occur in the same cycle.
  - Else if the counter reaches TIMEOUT-1: set rsp_err=1, rsp_data=0, go to RESP.
- RX: increment bit_cnt each cycle while data_done=1. Hold bit_cnt if data_done drops. When bit_cnt == MSG_W-1, capture rsp_data <= spi_rx_data on the next cycle, then go to RESP.
- RESP:
  - rsp_valid=1, rsp_id=cur_id, spi_cs=0.
  - rsp_data, rsp_id and rsp_err stay stable until rsp_valid && rsp_ready.
  - Then go to IDLE; rsp_valid and rsp_err fall the following cycle.
- Ready rules:
  - reqX_ready is never asserted outside IDLE.
  - reqX_ready is never asserted without reqX_valid.
  - Only one reqX_ready is high at a time.
- spi_cs:
  - Rises on entry to LOAD. Stays high through TX, WAIT and RX. Falls on entry to RESP.
  - Never high in IDLE.
- Latched job fields are not re-sampled mid-job; requester inputs may change freely after the handshake.
- Reset mid-job: immediate abort to IDLE. No response is produced, and spi_cs drops asynchronously.
- Counters are sized for MSG_W+KEY_W and TIMEOUT, with no wrap before their terminal value.

Test Plan:
- Single job: req0_valid, mode=0, msg=128'h0011..ff, key=256'h0001..1f.
  - Required: req0_ready pulses once, spi_load pulses 1 cycle later, spi_cs high.
  - Required: WAIT is entered 384 cycles after LOAD.
  - Stimulus: data_done raised, spi_rx_data=128'h8ea2..89.
  - Required: rsp_valid with rsp_id=0 and that data after 128 RX cycles.
- Contention: req0 and req1 both valid from reset.
  - Required: grant order 0,1,0,1 over four jobs.
  - Required: rsp_id sequence matches the grants.
- Timeout: data_done never asserted, TIMEOUT=16.
  - Required: rsp_err=1 and rsp_data=0 exactly 16 cycles after WAIT entry.
  - Required: spi_cs low in RESP.
- Backpressure: rsp_ready held low for 50 cycles.
  - Required: rsp_valid, rsp_data and rsp_id stable throughout.
  - Required: no new grant while req1_valid=1.
  - Required: grant on the cycle after IDLE is re-entered.
- Reset mid-TX: drop rst at bit_cnt=100.
  - Required: all outputs 0 asynchronously; IDLE on release; no rsp_valid.
  - Required: the next job runs a full 384-cycle TX.
- data_done glitch in RX: deassert for 5 cycles at bit 60.
  - Required: RX completes after 133 total cycles.
  - Required: capture happens only at count 127.
